// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port synchronous RAM.
// Each access takes two cycles: ACCESS drives the RAM and pulses GNTn, and
// RESP pulses DONEn and returns the RAM read data.
//
// Ports:
//   CLOCK, RESET           clock; synchronous active-high reset
//   REQ0/1, WE0/1          request and write strobe from requester 0/1
//   ADDR0/1, WDATA0/1      request address / write data
//   GNT0/1                 one-cycle grant pulse (ACCESS cycle)
//   DONE0/1                one-cycle completion pulse (RESP cycle)
//   RDATA                  read data, nonzero only while DONEn is high for a read
//   BUSY                   high in ACCESS and RESP
//   MEM_EN, MEM_WE         RAM enable / write enable, high only in ACCESS
//   MEM_ADDR, MEM_WDATA    RAM address / write data, held between accesses
//   MEM_RDATA              RAM read data, valid one cycle after a read enable
//
// Build option:
//   RAM_ARB_FIXED_PRIORITY_EN  requester 0 always wins simultaneous requests
//                              and the round-robin pointer is not built.
//                              Undefined (default): round-robin arbitration.

module ram_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              DONE0,
  output logic              DONE1,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;

  // Latched transaction: winner (1 = requester 1) and its write strobe.
  logic              winner_q;
  logic              winner_d;
  logic              we_q;
  logic              we_d;

  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  logic              gnt0_d;
  logic              gnt1_d;
  logic              done0_d;
  logic              done1_d;
  logic              busy_d;
  logic              mem_en_d;
  logic              mem_we_d;

  logic              any_req;
  logic              pick1;
  logic              start;

  assign any_req = REQ0 | REQ1;

  // Arbitration: pick1 says requester 1 wins if an access starts this edge.
`ifdef RAM_ARB_FIXED_PRIORITY_EN
  assign pick1 = REQ1 & ~REQ0;
`else
  // ptr_q names the requester favoured on a tie; it moves to the loser.
  logic ptr_q;
  logic ptr_d;

  assign pick1 = REQ1 & (~REQ0 | ptr_q);
`endif

  // Next-state, transaction latch and registered-output decode.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    we_d        = we_q;
    mem_addr_d  = MEM_ADDR;
    mem_wdata_d = MEM_WDATA;
    start       = 1'b0;
`ifndef RAM_ARB_FIXED_PRIORITY_EN
    ptr_d       = ptr_q;
`endif

    case (state_q)
      IDLE, RESP: begin
        if (any_req) begin
          state_d = ACCESS;
          start   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase

    if (start) begin
      winner_d    = pick1;
      we_d        = pick1 ? WE1 : WE0;
      mem_addr_d  = pick1 ? ADDR1 : ADDR0;
      mem_wdata_d = pick1 ? WDATA1 : WDATA0;
`ifndef RAM_ARB_FIXED_PRIORITY_EN
      ptr_d       = ~pick1;
`endif
    end

    // Outputs are registered, so they are decoded from the next state.
    gnt0_d   = start & ~pick1;
    gnt1_d   = start & pick1;
    mem_en_d = start;
    mem_we_d = start & we_d;
    done0_d  = (state_q == ACCESS) & ~winner_q;
    done1_d  = (state_q == ACCESS) & winner_q;
    busy_d   = (state_d != IDLE);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= IDLE;
      winner_q  <= 1'b0;
      we_q      <= 1'b0;
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
      DONE0     <= 1'b0;
      DONE1     <= 1'b0;
      BUSY      <= 1'b0;
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      we_q      <= we_d;
      GNT0      <= gnt0_d;
      GNT1      <= gnt1_d;
      DONE0     <= done0_d;
      DONE1     <= done1_d;
      BUSY      <= busy_d;
      MEM_EN    <= mem_en_d;
      MEM_WE    <= mem_we_d;
      MEM_ADDR  <= mem_addr_d;
      MEM_WDATA <= mem_wdata_d;
    end
  end

`ifndef RAM_ARB_FIXED_PRIORITY_EN
  // Round-robin pointer; reset favours requester 0.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // The RAM returns read data during RESP itself, so RDATA is a pass-through
  // gated by the RESP state; registering it would land one cycle after DONE.
  assign RDATA = ((state_q == RESP) && !we_q) ? MEM_RDATA : '0;

endmodule
